// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: padder FSM states, the padding marker word and
// the block/padding arithmetic used by both the padder and the hash core.
package sha256_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        EMIT,
        PAD
    } state_t;

    localparam logic [31:0] PAD_WORD = 32'h8000_0000;

    // 512-bit blocks needed for a message of num_words words: the message,
    // the 0x80000000 marker and the two-word bit length must all fit.
    function automatic int unsigned num_blocks(input int unsigned num_words);
        return (num_words + 3 + 15) / 16;
    endfunction

    // Word at stream position n when n is past the message body.
    function automatic logic [31:0] pad_word_sel(input int unsigned n,
                                                 input int unsigned num_words);
        int unsigned total;
        total = 16 * num_blocks(num_words);
        if (n == num_words) begin
            return PAD_WORD;
        end else if (n == total - 1) begin
            return 32'(num_words * 32'd32);
        end else begin
            return 32'h0000_0000;
        end
    endfunction

endpackage

// File: rtl/sha256_msg_padder.sv
// Reads a NUM_OF_WORDS-word message from a synchronous memory and emits the
// SHA-256 padded word stream (message, marker, zeros, bit length) over a
// valid/ready interface, one 16-word block after another.
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int unsigned NUM_OF_WORDS = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] message_addr,
    output logic        busy,
    output logic        done,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    input  logic [31:0] mem_read_data,
    output logic        w_valid,
    input  logic        w_ready,
    output logic [31:0] w_data,
    output logic [3:0]  w_index,
    output logic        w_last_block,
    output logic        w_last
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned TOTAL = 16 * num_blocks(NUM_OF_WORDS);
    localparam logic [CNT_W-1:0] MSG_N      = CNT_W'(NUM_OF_WORDS);
    localparam logic [CNT_W-1:0] LAST_N     = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] LAST_BLK_N = CNT_W'(TOTAL - 16);

    state_t            state;
    logic [15:0]       base;
    logic [CNT_W-1:0]  n;
    logic [CNT_W-1:0]  n_next_c;
    logic [31:0]       pad_next_c;

    assign mem_clk = clk;
    assign mem_we  = 1'b0;

    // Position and padding content of the word that follows the current one.
    assign n_next_c   = n + CNT_W'(1);
    assign pad_next_c = pad_word_sel(32'(n_next_c), NUM_OF_WORDS);

    // Stream sequencer. mem_addr is loaded on entry to REQ so the address is
    // on the bus during REQ and the memory answers during WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            base         <= '0;
            n            <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            mem_addr     <= '0;
            w_valid      <= 1'b0;
            w_data       <= '0;
            w_index      <= '0;
            w_last_block <= 1'b0;
            w_last       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        base     <= message_addr;
                        mem_addr <= message_addr;
                        n        <= '0;
                        busy     <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    state <= WAIT;
                end
                WAIT: begin
                    w_data       <= mem_read_data;
                    w_valid      <= 1'b1;
                    w_index      <= n[3:0];
                    w_last_block <= (n >= LAST_BLK_N);
                    w_last       <= (n == LAST_N);
                    state        <= EMIT;
                end
                EMIT: begin
                    if (w_ready) begin
                        n <= n_next_c;
                        if (n_next_c < MSG_N) begin
                            w_valid  <= 1'b0;
                            mem_addr <= 16'(base + n_next_c);
                            state    <= REQ;
                        end else begin
                            w_data       <= pad_next_c;
                            w_index      <= n_next_c[3:0];
                            w_last_block <= (n_next_c >= LAST_BLK_N);
                            w_last       <= (n_next_c == LAST_N);
                            state        <= PAD;
                        end
                    end
                end
                PAD: begin
                    if (w_ready) begin
                        if (n == LAST_N) begin
                            w_valid <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            n            <= n_next_c;
                            w_data       <= pad_next_c;
                            w_index      <= n_next_c[3:0];
                            w_last_block <= (n_next_c >= LAST_BLK_N);
                            w_last       <= (n_next_c == LAST_N);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Self-checking bench for sha256_msg_padder: three instances (20, 13 and 14
// words) against a word-position reference model of the padded stream.
module tb_sha256_msg_padder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start        [3];
    logic [15:0] maddr_in     [3];
    logic        busy         [3];
    logic        done         [3];
    logic        mem_clk      [3];
    logic        mem_we       [3];
    logic [15:0] mem_addr     [3];
    logic [31:0] rdata        [3];
    logic        w_valid      [3];
    logic        w_ready      [3];
    logic [31:0] w_data       [3];
    logic [3:0]  w_index      [3];
    logic        w_last_block [3];
    logic        w_last       [3];
    logic [31:0] salt         [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sha256_msg_padder #(.NUM_OF_WORDS(20)) u0 (
        .clk(clk), .reset(rst), .start(start[0]), .message_addr(maddr_in[0]),
        .busy(busy[0]), .done(done[0]), .mem_clk(mem_clk[0]), .mem_we(mem_we[0]),
        .mem_addr(mem_addr[0]), .mem_read_data(rdata[0]), .w_valid(w_valid[0]),
        .w_ready(w_ready[0]), .w_data(w_data[0]), .w_index(w_index[0]),
        .w_last_block(w_last_block[0]), .w_last(w_last[0]));

    sha256_msg_padder #(.NUM_OF_WORDS(13)) u1 (
        .clk(clk), .reset(rst), .start(start[1]), .message_addr(maddr_in[1]),
        .busy(busy[1]), .done(done[1]), .mem_clk(mem_clk[1]), .mem_we(mem_we[1]),
        .mem_addr(mem_addr[1]), .mem_read_data(rdata[1]), .w_valid(w_valid[1]),
        .w_ready(w_ready[1]), .w_data(w_data[1]), .w_index(w_index[1]),
        .w_last_block(w_last_block[1]), .w_last(w_last[1]));

    sha256_msg_padder #(.NUM_OF_WORDS(14)) u2 (
        .clk(clk), .reset(rst), .start(start[2]), .message_addr(maddr_in[2]),
        .busy(busy[2]), .done(done[2]), .mem_clk(mem_clk[2]), .mem_we(mem_we[2]),
        .mem_addr(mem_addr[2]), .mem_read_data(rdata[2]), .w_valid(w_valid[2]),
        .w_ready(w_ready[2]), .w_data(w_data[2]), .w_index(w_index[2]),
        .w_last_block(w_last_block[2]), .w_last(w_last[2]));

    // Synchronous memories: mem[a] = salt + a, data one cycle after address.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) rdata[i] <= salt[i] + {16'h0, mem_addr[i]};
    end

    function automatic int nw_of(input int k);
        case (k)
            0:       return 20;
            1:       return 13;
            default: return 14;
        endcase
    endfunction

    // Padded length: message + marker + 64-bit length, rounded up to 16 words.
    function automatic int total_of(input int k);
        int w;
        w = nw_of(k) + 1 + 2;
        return ((w + 15) / 16) * 16;
    endfunction

    function automatic logic [31:0] model_word(input int k, input int n,
                                               input logic [15:0] addr,
                                               input logic [31:0] s);
        logic [15:0] a;
        a = addr + 16'(n);
        if (n < nw_of(k))            return s + {16'h0, a};
        if (n == nw_of(k))           return 32'h8000_0000;
        if (n == total_of(k) - 1)    return 32'(nw_of(k)) * 32'd32;
        return 32'h0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=0x%0h exp=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_rst_vals(input int k);
        check("rst_busy", 32'(busy[k]), 0);
        check("rst_done", 32'(done[k]), 0);
        check("rst_w_valid", 32'(w_valid[k]), 0);
        check("rst_w_data", w_data[k], 0);
        check("rst_w_index", 32'(w_index[k]), 0);
        check("rst_w_last_block", 32'(w_last_block[k]), 0);
        check("rst_w_last", 32'(w_last[k]), 0);
        check("rst_mem_addr", 32'(mem_addr[k]), 0);
        check("rst_mem_we", 32'(mem_we[k]), 0);
    endtask

    // mode 0: ready always high, 1: random ready, 2: stalls at st1/st2 for stl cycles
    task automatic run_stream(input int k, input logic [15:0] addr, input logic [31:0] s,
                              input int mode, input int st1, input int st2, input int stl,
                              input int rst_at, input int restart_at,
                              output int got, output logic [31:0] final_word);
        int nw, total, last_hs, stall_cnt, stall_tag;
        bit fin_seen, done_seen, aborted, restarted, hold_prev;
        logic [31:0] p_data;
        logic [3:0]  p_index;
        logic        p_lb, p_last, rdy;
        logic [15:0] p_ma, prev_ma, off;
        nw = nw_of(k);
        total = total_of(k);
        got = 0; last_hs = 0; stall_cnt = 0; stall_tag = -1;
        fin_seen = 0; done_seen = 0; aborted = 0; restarted = 0; hold_prev = 0;
        final_word = 32'h0;
        p_data = '0; p_index = '0; p_lb = 0; p_last = 0; p_ma = '0;
        salt[k] = s;
        @(posedge clk); #1;
        maddr_in[k] = addr; start[k] = 1'b1; w_ready[k] = 1'b0;
        @(posedge clk); #1;
        start[k] = 1'b0; maddr_in[k] = ~addr;
        check("busy_after_start", 32'(busy[k]), 1);
        check("mem_addr_first", 32'(mem_addr[k]), 32'(addr));
        prev_ma = addr;
        for (int cyc = 0; cyc < 3000 && !done_seen && !aborted; cyc++) begin
            if (got != stall_tag) begin stall_tag = got; stall_cnt = 0; end
            rdy = 1'b1;
            if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
            if (mode == 2 && w_valid[k] && (got == st1 || got == st2) && stall_cnt < stl) begin
                rdy = 1'b0;
                stall_cnt++;
            end
            w_ready[k] = rdy;
            if (restart_at >= 0 && got == restart_at && w_valid[k] && !restarted) begin
                start[k] = 1'b1; maddr_in[k] = addr + 16'h0100; restarted = 1;
            end else begin
                start[k] = 1'b0;
            end
            if (rst_at >= 0 && got == rst_at && w_valid[k]) begin
                rst = 1'b1;
                #1;
                check_rst_vals(k);
                @(negedge clk);
                check("rst_hold_done", 32'(done[k]), 0);
                @(posedge clk); #1;
                rst = 1'b0; w_ready[k] = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    check("post_rst_done", 32'(done[k]), 0);
                    check("post_rst_valid", 32'(w_valid[k]), 0);
                end
                aborted = 1;
            end else begin
                @(negedge clk);
                if (hold_prev) begin
                    check("stall_valid", 32'(w_valid[k]), 1);
                    check("stall_data", w_data[k], p_data);
                    check("stall_index", 32'(w_index[k]), 32'(p_index));
                    check("stall_last_block", 32'(w_last_block[k]), 32'(p_lb));
                    check("stall_last", 32'(w_last[k]), 32'(p_last));
                    check("stall_mem_addr", 32'(mem_addr[k]), 32'(p_ma));
                end
                if (mem_addr[k] != prev_ma) begin
                    off = mem_addr[k] - addr;
                    check("mem_addr_in_msg", 32'(off < 16'(nw)), 1);
                    prev_ma = mem_addr[k];
                end
                check("done_timing", 32'(done[k]), 32'(fin_seen));
                if (fin_seen) begin
                    check("busy_after_last", 32'(busy[k]), 0);
                    check("valid_after_last", 32'(w_valid[k]), 0);
                    done_seen = 1;
                end else begin
                    check("busy_level", 32'(busy[k]), 1);
                end
                hold_prev = 0;
                if (w_valid[k] && w_ready[k] && !fin_seen) begin
                    check("word", w_data[k], model_word(k, got, addr, s));
                    check("index", 32'(w_index[k]), 32'(got % 16));
                    check("last_block", 32'(w_last_block[k]), 32'(got >= total - 16));
                    check("last", 32'(w_last[k]), 32'(got == total - 1));
                    if (mode == 0 && got > 0)
                        check("gap", 32'(cyc - last_hs), (got < nw) ? 32'd3 : 32'd1);
                    last_hs = cyc;
                    final_word = w_data[k];
                    got++;
                    if (got == total) fin_seen = 1;
                end else if (w_valid[k]) begin
                    hold_prev = 1;
                    p_data = w_data[k]; p_index = w_index[k];
                    p_lb = w_last_block[k]; p_last = w_last[k]; p_ma = mem_addr[k];
                end
                @(posedge clk); #1;
            end
        end
        w_ready[k] = 1'b0;
        start[k] = 1'b0;
        if (!aborted) begin
            check("stream_completed", 32'(done_seen), 1);
            @(negedge clk);
            check("done_one_cycle", 32'(done[k]), 0);
        end
    endtask

    typedef struct {
        int          k;
        logic [15:0] addr;
        logic [31:0] s;
        int          mode, st1, st2, stl, rst_at, restart_at;
        int          exp_words;
        bit          chk_final;
        logic [31:0] exp_final;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int          got, k;
        logic [31:0] fw, s;
        logic [15:0] addr;

        tbl[0] = '{0, 16'h0000, 32'hA000_0000, 0, -1, -1, 0, -1, -1, 32, 1'b1, 32'h0000_0280};
        tbl[1] = '{1, 16'h0040, 32'h1234_5678, 0, -1, -1, 0, -1, -1, 16, 1'b1, 32'h0000_01A0};
        tbl[2] = '{2, 16'hFFF8, 32'hDEAD_BEEF, 0, -1, -1, 0, -1, -1, 32, 1'b1, 32'h0000_01C0};
        tbl[3] = '{0, 16'h0000, 32'hA000_0000, 2,  3, 25, 5, -1, -1, 32, 1'b1, 32'h0000_0280};
        tbl[4] = '{0, 16'h0200, 32'hA000_0000, 0, -1, -1, 0, -1, 10, 32, 1'b1, 32'h0000_0280};
        tbl[5] = '{0, 16'h0000, 32'hA000_0000, 0, -1, -1, 0,  7, -1,  7, 1'b0, 32'h0};

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0; maddr_in[i] = '0; w_ready[i] = 1'b0; salt[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) check_rst_vals(i);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            run_stream(tbl[v].k, tbl[v].addr, tbl[v].s, tbl[v].mode, tbl[v].st1,
                       tbl[v].st2, tbl[v].stl, tbl[v].rst_at, tbl[v].restart_at, got, fw);
            check($sformatf("tbl%0d_words", v), 32'(got), 32'(tbl[v].exp_words));
            if (tbl[v].chk_final) check($sformatf("tbl%0d_final", v), fw, tbl[v].exp_final);
        end

        // Full stream right after the mid-stream reset starts again from word 0.
        run_stream(0, 16'h0010, 32'hA000_0000, 0, -1, -1, 0, -1, -1, got, fw);
        check("restart_words", 32'(got), 32);
        check("restart_final", fw, 32'h0000_0280);

        // Random backpressure, addresses and memory contents.
        for (int r = 0; r < 6; r++) begin
            k = $urandom_range(0, 2);
            addr = 16'($urandom);
            if (r % 2 == 1) addr = 16'hFFF0 | 16'($urandom_range(0, 15));
            s = $urandom;
            run_stream(k, addr, s, 1, -1, -1, 0, -1, -1, got, fw);
            check("rand_words", 32'(got), 32'(total_of(k)));
            check("rand_final", fw, 32'(nw_of(k)) * 32'd32);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sha256_msg_padder.md
SHA256_MSG_PADDER -- requirements
Module: sha256_msg_padder

Interface
REQ-001 SHALL have parameter NUM_OF_WORDS, default 20, meaning message length in 32-bit words (legal range 1..4000).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  begin one padded message stream; sampled only in IDLE.
REQ-005 SHALL have port message_addr  input  16  word address of message word 0; captured when start is accepted.
REQ-006 SHALL have port busy  output  1  high from the cycle after start acceptance until the final word handshake.
REQ-007 SHALL have port done  output  1  one-cycle pulse in the cycle after the final word handshake.
REQ-008 SHALL have ports mem_clk  output  1 (= clk), mem_we  output  1 (tied 0), mem_addr  output  16 (read address).
REQ-009 SHALL have port mem_read_data  input  32  memory data, valid exactly one cycle after mem_addr is presented.
REQ-010 SHALL have ports w_valid  output  1, w_ready  input  1, w_data  output  32 (padded word stream to the hash core).
REQ-011 SHALL have ports w_index  output  4 (word position in block), w_last_block  output  1 (word belongs to final block), w_last  output  1 (final word of stream).

Function
REQ-012 SHALL emit TOTAL = 16*NB words, NB = ceil((NUM_OF_WORDS+3)/16), in ascending order; word n denotes stream position.
REQ-013 SHALL emit, for n < NUM_OF_WORDS, the memory word at message_addr+n; for n = NUM_OF_WORDS, 0x80000000; for n = TOTAL-1, 32*NUM_OF_WORDS (mod 2^32); for all other n, 0x00000000.
REQ-014 SHALL use FSM states IDLE, REQ, WAIT, EMIT, PAD.
REQ-015 IDLE: on start, capture message_addr, clear n, go to REQ; start is ignored in every other state.
REQ-016 REQ: drive mem_addr = message_addr + n (16-bit wrap), go to WAIT.
REQ-017 WAIT: register mem_read_data into w_data, assert w_valid, go to EMIT.
REQ-018 EMIT: hold w_valid/w_data until w_valid&&w_ready, then increment n; go to REQ if n+1 < NUM_OF_WORDS, else go to PAD with the word for n+1 already loaded and w_valid held high.
REQ-019 PAD: present the REQ-013 word for n; on handshake load the next word in the same edge (one word per cycle with w_ready high); after handshake of word TOTAL-1 drop w_valid, pulse done, go to IDLE.
REQ-020 SHALL keep w_data, w_index, w_last_block, w_last stable while w_valid && !w_ready; w_valid SHALL NOT drop without a handshake.
REQ-021 w_index SHALL be n[3:0]; w_last_block SHALL be high iff n >= TOTAL-16; w_last SHALL be high iff n = TOTAL-1.
REQ-022 mem_addr SHALL hold its last value outside REQ; no memory read SHALL be issued for n >= NUM_OF_WORDS.
REQ-023 Message-word throughput SHALL be one word per 3 cycles with w_ready held high; padding one word per cycle.

Reset
REQ-024 While reset is high: state IDLE, busy 0, done 0, w_valid 0, w_data 0, w_index 0, w_last_block 0, w_last 0, mem_addr 0, n 0; mem_we SHALL remain 0.
REQ-025 Reset mid-stream SHALL abort immediately with no done pulse; the next start SHALL restart from word 0.

Structure
REQ-026 Shared package sha256_pkg SHALL hold the state enum, PAD_WORD constant 0x80000000, and a function computing NB from word count.
REQ-027 No sub-module; the padding-word select SHALL be a package function reused by the hash core.

Verification
REQ-028 NUM_OF_WORDS=20, mem[i]=0xA0000000+i, w_ready=1 -> 32 words; words 0..19 match memory, word 20=0x80000000, words 21..30=0, word 31=0x00000280, w_last_block high for n 16..31, done one cycle after word 31.
REQ-029 NUM_OF_WORDS=13 -> 16 words; word 13=0x80000000, word 14=0, word 15=0x000001A0, w_last_block high throughout.
REQ-030 NUM_OF_WORDS=14 -> 32 words; word 14=0x80000000, word 15=0, word 31=0x000001C0.
REQ-031 NUM_OF_WORDS=20, w_ready low 5 cycles at word 3 and at word 25 -> w_data/w_valid stable, mem_addr frozen, no word lost or duplicated.
REQ-032 reset pulsed during word 7 -> all outputs at reset values same cycle, no done; subsequent start yields full correct 32-word stream.
REQ-033 start pulsed while busy at word 10 -> ignored; stream and done unaffected.
